// File: rtl/shift_pipe.sv
// Two-stage pipelined 32-bit shifter (SLL/SRL/SRA): a coarse shift by multiples of 4,
// then a fine shift by 0-3. Both stages are registered and use valid/ready handshakes.
module shift_pipe #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [4:0]   in_shamt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [15:0]  out_count
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } op_t;

  logic         s1_valid;
  logic [N-1:0] s1_data;
  logic [1:0]   s1_fine;
  op_t          s1_op;
  logic         s1_sign;

  logic s2_free;
  logic s1_adv;
  logic accept;
  logic deliver;

  function automatic logic [N-1:0] coarse_shift(input logic [N-1:0] d,
                                                input logic [2:0]   grp,
                                                input op_t          op);
    logic [4:0] amt;
    amt = {grp, 2'b00};
    case (op)
      OP_SLL:  coarse_shift = d << amt;
      OP_SRL:  coarse_shift = d >> amt;
      OP_SRA:  coarse_shift = $signed(d) >>> amt;
      default: coarse_shift = '0;
    endcase
  endfunction

  // The operand's original sign bit is carried separately so the fine SRA fill stays
  // correct even when the coarse stage did not move any sign bits into the MSB.
  function automatic logic [N-1:0] fine_shift(input logic [N-1:0] d,
                                              input logic [1:0]   amt,
                                              input logic         sign,
                                              input op_t          op);
    logic [N-1:0] ones;
    ones = '1;
    case (op)
      OP_SLL:  fine_shift = d << amt;
      OP_SRL:  fine_shift = d >> amt;
      OP_SRA:  fine_shift = sign ? ((d >> amt) | ~(ones >> amt)) : (d >> amt);
      default: fine_shift = '0;
    endcase
  endfunction

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // Stage 1: coarse shift; reloads directly when an accept coincides with an advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_fine  <= '0;
      s1_op    <= OP_SLL;
      s1_sign  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= coarse_shift(in_data, in_shamt[4:2], op_t'(in_op));
      s1_fine  <= in_shamt[1:0];
      s1_op    <= op_t'(in_op);
      s1_sign  <= in_data[N-1];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: fine shift into the output register; flush drops valid but keeps data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= fine_shift(s1_data, s1_fine, s1_sign, s1_op);
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  // A delivery completing on a flush edge still counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_count <= '0;
    end else if (deliver) begin
      out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: expected results are queued on accept and
// compared on delivery; directed sections cover latency, stalls, flush and reset.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          start_cycle;
  logic [31:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;

  shift_pipe #(.N(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b11:   return 32'($signed(d) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Mid-cycle monitor: inputs and outputs are stable here, so this sees exactly
  // the transfers that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        exp_count = exp_count + 16'd1;
        if (exp_q.size() == 0) checkOutput("unexpected_result", 1, 0);
        else checkOutput("result", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt, in_op));
    end
  end

  task automatic waitAccept();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] sh,
                               input logic [1:0] op);
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_valid = 1'b1;
    waitAccept();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_shamt = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_count", 32'(out_count), 0);
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic ops and latency");
    applyStimulus(32'h80000001, 5'd4, 2'b11);
    #1;
    checkOutput("latency_early", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("latency_valid", 32'(out_valid), 1);
    checkOutput("latency_data", out_data, 32'hF8000000);
    applyStimulus(32'h80000001, 5'd4, 2'b01);
    applyStimulus(32'h80000001, 5'd31, 2'b00);
    waitDrain();
    checkOutput("basic_count", 32'(out_count), 3);

    $display("[TB] boundary shift amounts");
    applyStimulus(32'h7FFFFFFF, 5'd31, 2'b11);
    applyStimulus(32'h80000000, 5'd31, 2'b11);
    applyStimulus(32'hDEADBEEF, 5'd0,  2'b01);
    applyStimulus(32'h00000001, 5'd5,  2'b00);
    waitDrain();
    checkOutput("boundary_count", 32'(out_count), 32'(exp_count));

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h12345678, 5'd8, 2'b00);
    applyStimulus(32'hF0F0F0F0, 5'd3, 2'b11);
    in_data = 32'h0000FFFF; in_shamt = 5'd16; in_op = 2'b01; in_valid = 1'b1;
    repeat (3) begin
      #1;
      checkOutput("stall_in_ready", 32'(in_ready), 0);
      checkOutput("stall_out_valid", 32'(out_valid), 1);
      checkOutput("stall_out_data", out_data, 32'h34567800);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    waitAccept();
    waitDrain();
    checkOutput("bp_in_ready", 32'(in_ready), 1);
    checkOutput("bp_count", 32'(out_count), 32'(exp_count));

    $display("[TB] back-to-back streaming");
    start_cycle = cycle;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      applyStimulus($urandom, 5'($urandom_range(0, 31)), op);
    end
    checkOutput("stream_cycles", 32'(cycle - start_cycle), 16);
    waitDrain();
    checkOutput("stream_count", 32'(out_count), 32'(exp_count));

    $display("[TB] flush with both stages full");
    out_ready = 1'b0;
    applyStimulus(32'h00000001, 5'd5, 2'b00);
    applyStimulus(32'hCAFEF00D, 5'd9, 2'b01);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    checkOutput("flush_out_valid", 32'(out_valid), 0);
    checkOutput("flush_out_data", out_data, 32'h00000020);
    checkOutput("flush_in_ready_after", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    checkOutput("flush_s1_dropped", 32'(out_valid), 0);
    out_ready = 1'b1;
    applyStimulus(32'hDEADBEEF, 5'd0, 2'b01);
    waitDrain();
    checkOutput("flush_count", 32'(out_count), 32'(exp_count));

    $display("[TB] flush coinciding with a delivery");
    out_ready = 1'b0;
    applyStimulus(32'h0000000F, 5'd2, 2'b00);
    applyStimulus(32'h000000F0, 5'd2, 2'b01);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    checkOutput("flush_deliver_valid", 32'(out_valid), 0);
    checkOutput("flush_deliver_count", 32'(out_count), 32'(exp_count));
    waitDrain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(32'h13579BDF, 5'd6, 2'b11);
    applyStimulus(32'h2468ACE0, 5'd1, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 0);
    checkOutput("midreset_out_count", 32'(out_count), 0);
    checkOutput("midreset_out_data", out_data, 0);
    exp_q.delete();
    exp_count = 16'd0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postreset_in_ready", 32'(in_ready), 1);
    checkOutput("postreset_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    applyStimulus(32'hFFFFFFFF, 5'd7, 2'b10);
    #1;
    @(posedge clk);
    #1;
    checkOutput("reserved_op_data", out_data, 32'h00000000);
    waitDrain();
    checkOutput("postreset_count", 32'(out_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Two-stage pipelined shift execution unit with valid/ready handshakes on both sides.
- It sits between the decode/operand-fetch stage and the writeback mux.
- It performs SLL, SRL and SRA on 32-bit operands and replaces the single-cycle combinational shifter path when timing requires it.
- The shift is decomposed into a coarse stage (multiples of 4) and a fine stage (0-3), each followed by a register.

Parameters:
- N, 32: data width. Fixed constant; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards in-flight ops.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  32  operand to shift.
- in_shamt  input  5  shift amount, 0-31.
- in_op  input  2  operation select: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  shifted result.
- out_count  output  16  number of results delivered (out_valid && out_ready); wraps.

Behaviour:
- Reset (rst=0, asynchronous), cleared:
  - s1_valid=0, out_valid=0, out_data=0, out_count=0.
  - All stage-1 payload registers = 0.
  - in_ready is combinational and therefore reads 1 after reset.
- Transfer rules:
  - Accept: in_valid && in_ready at a clock edge.
  - Deliver: out_valid && out_ready at a clock edge.
- Stage 1 (coarse), on accept:
  - s1_data = in_data shifted by 4*in_shamt[4:2].
  - Left shift for SLL; right shift for SRL/SRA.
  - Fill: zeros for SLL/SRL; in_data[31] replicated for SRA.
  - Also registered: s1_fine=in_shamt[1:0], s1_op=in_op, s1_sign=in_data[31], s1_valid=1.
- Stage 2 (fine/output):
  - When s1 advances, out_data = s1_data shifted by s1_fine.
  - Same direction and fill rules as stage 1; the SRA fill uses s1_sign.
  - out_valid=1.
- Reserved op 10 follows the full pipeline path and produces out_data=0.
- Advance conditions:
  - s2_free = !out_valid || out_ready.
  - s1 advances when s1_valid && s2_free.
  - in_ready = !flush && (!s1_valid || s2_free).
- Latency and throughput:
  - Accept at edge k gives out_valid=1 after edge k+1, with no stalls.
  - Full throughput is 1 op/cycle while out_ready=1.
- Backpressure:
  - When out_valid && !out_ready, out_data/out_valid hold stable.
  - s1 holds; in_ready drops once s1 is occupied.
  - No op is lost or duplicated.
- Simultaneous events:
  - Deliver and s1-advance on the same edge: the new result replaces the old one; out_valid stays 1.
  - Accept and s1-advance on the same edge: s1 reloads with the new op; s1_valid stays 1.
- flush=1 at an edge:
  - s1_valid=0 and out_valid=0; no accept (in_ready=0).
  - out_count increments if a deliver occurs on that same edge; flush does not block a completing deliver.
  - out_data is unchanged.
- Reset mid-operation clears everything immediately; in-flight ops are dropped.
- out_count increments by 1 per deliver, modulo 2^16 (0xFFFF -> 0x0000).
- Shift amount 0 passes in_data through unchanged for all valid ops.

Test Plan:
- Basic ops, out_ready=1, data 0x80000001:
  - SRA shamt=4 -> 0xF8000000.
  - SRL shamt=4 -> 0x08000000.
  - SLL shamt=31 -> 0x80000000.
  - Each appears 2 cycles after accept; out_count=3.
- Boundary shamts:
  - SRA 0x7FFFFFFF by 31 -> 0x00000000.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SRL 0xDEADBEEF by 0 -> 0xDEADBEEF.
  - SLL 0x00000001 by 5 -> 0x00000020 (crosses the coarse/fine split: 4+1).
- Backpressure:
  - Hold out_ready=0 and stream 3 ops.
  - Exactly 2 are accepted; in_ready=0 afterwards; out_data stable.
  - Release out_ready: results emerge in order, then in_ready returns to 1.
- Back-to-back streaming:
  - 16 random ops with out_ready=1 every cycle.
  - One result per cycle after 2-cycle fill; all match the reference model.
- Flush with both stages full:
  - Assert flush for 1 cycle with out_ready=0.
  - Both valids drop; in_ready=0 during flush; the next accepted op is the first result seen.
- Reset mid-stream:
  - Drop rst asynchronously between edges.
  - out_valid=0, out_count=0, out_data=0 immediately; after release, in_ready=1.
  - Reserved op 10 afterwards returns 0x00000000.
